// File: rtl/keypad_scan_decoder_pkg.sv
// Shared keypad types and constants: scan FSM states, matrix size and the
// (row, column) to hex-code keymap.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kp_state_e;

    // Keypad legend: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D,
    // with '*' reported as E and '#' reported as F.
    function automatic logic [3:0] kp_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_decoder_if.sv
// Key delivery bus: decoded code with valid/ack handshake, sticky overrun flag
// and the history of the last four accepted codes.
interface keypad_scan_decoder_if;

    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        overrun;
    logic [15:0] digits;

    // Decoder side produces keys, consumer side acknowledges them.
    modport master (
        output key_code,
        output key_valid,
        output overrun,
        output digits,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  overrun,
        input  digits,
        output key_ack
    );

endinterface

// File: rtl/keypad_scan_decoder_scan_tick_gen.sv
// Row-dwell divider: produces a one-clock tick every SCAN_DIV clocks.
module scan_tick_gen #(
    parameter int SCAN_DIV = 150000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div;

    assign tick = (r_div == DIV_LAST);

    // Free-running divider that wraps to zero on the tick cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 active-low matrix keypad scanner: synchronizes the columns, walks one
// low row per tick, debounces press and release over DEBOUNCE_SCANS tick
// samples, and delivers each accepted key on a valid/ack handshake.
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 150000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KP_COLS-1:0]    col_in,
    output logic [KP_ROWS-1:0]    row_out,
    keypad_scan_decoder_if.master kp_if
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

    logic               w_tick;
    logic [KP_COLS-1:0] r_col_p0;
    logic [KP_COLS-1:0] r_col_p1;

    kp_state_e          r_state;
    kp_state_e          w_state_nxt;
    logic [1:0]         r_row;
    logic [1:0]         w_row_nxt;
    logic [1:0]         r_col_idx;
    logic [1:0]         w_col_idx_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic               w_hit;
    logic [1:0]         w_hit_col;
    logic               w_same;
    logic               w_col_high;
    logic               w_event;
    logic [3:0]         w_code;

    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_overrun;
    logic [15:0]        r_digits;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign row_out    = ~(KP_ROWS'(1) << r_row);
    assign w_same     = (r_col_p1 == ~(KP_COLS'(1) << r_col_idx));
    assign w_col_high = r_col_p1[r_col_idx];
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_code     = kp_map(r_row, r_col_idx);

    // Two-flop synchronizer for the asynchronous column inputs (idle = all high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_p0 <= '1;
            r_col_p1 <= '1;
        end else begin
            r_col_p0 <= col_in;
            r_col_p1 <= r_col_p0;
        end
    end

    // A hit is exactly one low column; none or several low (ghosting) is rejected.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_col = 2'd0;
        case (r_col_p1)
            4'b1110: begin w_hit = 1'b1; w_hit_col = 2'd0; end
            4'b1101: begin w_hit = 1'b1; w_hit_col = 2'd1; end
            4'b1011: begin w_hit = 1'b1; w_hit_col = 2'd2; end
            4'b0111: begin w_hit = 1'b1; w_hit_col = 2'd3; end
            default: begin w_hit = 1'b0; w_hit_col = 2'd0; end
        endcase
    end

    // Scan FSM state, current row, captured column and debounce count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= SCAN;
            r_row     <= 2'd0;
            r_col_idx <= 2'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_col_idx <= w_col_idx_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state logic; everything moves only on tick, the row only while scanning.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_col_idx_nxt = r_col_idx;
        w_cnt_nxt     = r_cnt;
        w_event       = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                SCAN: begin
                    if (w_hit) begin
                        w_col_idx_nxt = w_hit_col;
                        w_cnt_nxt     = CNT_W'(1);
                        w_state_nxt   = DEBOUNCE;
                    end else begin
                        w_row_nxt = r_row + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_same) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_LAST) begin
                            w_state_nxt = PRESSED;
                            w_cnt_nxt   = '0;
                            w_event     = 1'b1;
                        end
                    end else begin
                        w_state_nxt = SCAN;
                        w_cnt_nxt   = '0;
                        w_row_nxt   = r_row + 2'd1;
                    end
                end
                PRESSED: begin
                    if (w_col_high) begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_col_high) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_LAST) begin
                            w_state_nxt = SCAN;
                            w_cnt_nxt   = '0;
                            w_row_nxt   = r_row + 2'd1;
                        end
                    end else begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Key delivery: a new key wins over an ack in the same cycle and keeps valid high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_digits    <= 16'h0000;
        end else if (w_event) begin
            r_key_code  <= w_code;
            r_key_valid <= 1'b1;
            r_digits    <= {r_digits[11:0], w_code};
            if (r_key_valid && !kp_if.key_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (r_key_valid && kp_if.key_ack) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign kp_if.key_code  = r_key_code;
    assign kp_if.key_valid = r_key_valid;
    assign kp_if.overrun   = r_overrun;
    assign kp_if.digits    = r_digits;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: a tick-level behavioural model of the
// keypad decoder, a physical 4x4 matrix, directed scenarios and random presses.
module tb_keypad_scan_decoder;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] pressed = 16'h0000;
    bit          chk_en  = 1'b0;
    int          n_vec   = 0;
    int          n_bad   = 0;

    keypad_scan_decoder_if kp_if();

    keypad_scan_decoder #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .col_in  (col_in),
        .row_out (row_out),
        .kp_if   (kp_if)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] row_mask(input int r);
        logic [3:0] m;
        m = 4'b0001 << r;
        return ~m;
    endfunction

    // Switch matrix: a closed key pulls its column low while its row is driven low.
    function automatic logic [3:0] phys(input logic [3:0] rows_n, input logic [15:0] keys);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (!rows_n[r] && keys[r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    assign col_in = phys(row_out, pressed);

    // ---------------- behavioural model ----------------
    int          m_row, m_div, m_lock, m_run, m_events = 0;
    bit          m_held;
    logic [3:0]  m_s1, m_s2, m_code;
    logic        m_valid, m_ovr;
    logic [15:0] m_digits;

    task automatic model_reset();
        m_row = 0; m_div = 0; m_lock = -1; m_run = 0; m_held = 0;
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_code = 4'h0; m_valid = 1'b0; m_ovr = 1'b0; m_digits = 16'h0;
    endtask

    task automatic model_step();
        logic [3:0] cnow, smp, evcode;
        int nlow, c;
        bit ev;
        cnow = phys(row_mask(m_row), pressed);
        smp = m_s2; ev = 0; evcode = 4'h0;
        if (m_div == SD - 1) begin
            nlow = 0; c = 0;
            for (int k = 0; k < 4; k++) if (!smp[k]) begin nlow++; c = k; end
            if (m_lock < 0) begin
                if (nlow == 1) begin m_lock = c; m_run = 1; end
                else m_row = (m_row + 1) % 4;
            end else if (!m_held) begin
                if (nlow == 1 && c == m_lock) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_held = 1; m_run = 0; ev = 1;
                        evcode = KEYMAP[m_row*4 + m_lock];
                    end
                end else begin
                    m_lock = -1; m_run = 0; m_row = (m_row + 1) % 4;
                end
            end else begin
                if (smp[m_lock]) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_lock = -1; m_held = 0; m_run = 0; m_row = (m_row + 1) % 4;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        m_div = (m_div + 1) % SD;
        m_s2 = m_s1; m_s1 = cnow;
        if (ev) begin
            if (m_valid && !kp_if.key_ack) m_ovr = 1'b1;
            m_code = evcode; m_valid = 1'b1;
            m_digits = {m_digits[11:0], evcode};
            m_events++;
        end else if (m_valid && kp_if.key_ack) begin
            m_valid = 1'b0; m_ovr = 1'b0;
        end
    endtask

    // Model advances with the DUT clock and resets with it asynchronously.
    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("row_out", 16'(row_out), 16'(row_mask(m_row)));
        chk("key_valid", 16'(kp_if.key_valid), 16'(m_valid));
        chk("key_code", 16'(kp_if.key_code), 16'(m_code));
        chk("overrun", 16'(kp_if.overrun), 16'(m_ovr));
        chk("digits", kp_if.digits, m_digits);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row"}, 16'(row_out), 16'h000E);
        chk({tag, "_valid"}, 16'(kp_if.key_valid), 16'h0);
        chk({tag, "_code"}, 16'(kp_if.key_code), 16'h0);
        chk({tag, "_ovr"}, 16'(kp_if.overrun), 16'h0);
        chk({tag, "_digits"}, kp_if.digits, 16'h0);
    endtask

    task automatic tick_windows(input int n);
        repeat (n * SD) @(negedge clk);
    endtask

    task automatic wait_idle_row(input int r);
        int k;
        k = 0;
        while (!(m_lock < 0 && m_row == r && m_div == 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            n_vec++; n_bad++;
            $display("FAIL wait_idle_row: row %0d never reached idle within 400 clk", r);
        end
    endtask

    task automatic press_key(input int r, input int c, input int n);
        wait_idle_row(r);
        pressed[r*4 + c] = 1'b1;
        tick_windows(n);
        pressed[r*4 + c] = 1'b0;
        tick_windows(DB + 1);
    endtask

    task automatic do_ack();
        kp_if.key_ack = 1'b1;
        @(negedge clk);
        kp_if.key_ack = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_stimulus();
        int ev0, k, hold;
        logic [3:0] r0;
        logic [15:0] pat;
        kp_if.key_ack = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk_reset_vals("por");
        reset = 1'b1;

        // Idle scan: one row step every SD clocks, never a key.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3) chk("scan_row_hold", 16'(row_out), 16'h000E);
            if (i % 4 == 0) chk("scan_row", 16'(row_out), 16'(row_mask((i / 4) % 4)));
            chk("scan_novalid", 16'(kp_if.key_valid), 16'h0);
        end

        // Key 8 held for 10 ticks: exactly one event.
        ev0 = m_events;
        press_key(2, 1, 10);
        chk("k8_events", 16'(m_events - ev0), 16'd1);
        chk("k8_code", 16'(kp_if.key_code), 16'h0008);
        chk("k8_digits", kp_if.digits, 16'h0008);
        do_ack();

        // Bounce: 2 ticks low, 1 high, then a steady press.
        ev0 = m_events;
        wait_idle_row(1);
        pressed[6] = 1'b1; tick_windows(2);
        pressed[6] = 1'b0; tick_windows(1);
        pressed[6] = 1'b1; tick_windows(8);
        pressed[6] = 1'b0; tick_windows(DB + 1);
        chk("bounce_events", 16'(m_events - ev0), 16'd1);
        chk("bounce_code", 16'(kp_if.key_code), 16'h0006);
        do_ack();

        // Four keys without ack: overrun after the second.
        pulse_reset();
        press_key(0, 0, 4);
        chk("ovr_first", 16'(kp_if.overrun), 16'h0);
        press_key(0, 1, 4);
        chk("ovr_second", 16'(kp_if.overrun), 16'h1);
        press_key(0, 2, 4);
        press_key(0, 3, 4);
        chk("ovr_code", 16'(kp_if.key_code), 16'h000A);
        chk("ovr_digits", kp_if.digits, 16'h123A);
        do_ack();
        chk("ack_valid", 16'(kp_if.key_valid), 16'h0);
        chk("ack_ovr", 16'(kp_if.overrun), 16'h0);

        // Ghost: two columns low on one row.
        ev0 = m_events;
        wait_idle_row(3);
        pressed[12] = 1'b1; pressed[13] = 1'b1;
        tick_windows(1);
        chk("ghost_row", 16'(row_out), 16'h000E);
        tick_windows(5);
        pressed[12] = 1'b0; pressed[13] = 1'b0;
        tick_windows(2);
        chk("ghost_events", 16'(m_events - ev0), 16'd0);

        // Ack in the same cycle as a new event.
        press_key(1, 1, 4);
        chk("co_pre_valid", 16'(kp_if.key_valid), 16'h1);
        wait_idle_row(2);
        pressed[10] = 1'b1;
        k = 0;
        while (!(m_lock >= 0 && !m_held && m_run == DB - 1 && m_div == SD - 1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_vec++; n_bad++;
            $display("FAIL coincident_wait: event edge not reached within 200 clk");
        end
        do_ack();
        chk("co_valid", 16'(kp_if.key_valid), 16'h1);
        chk("co_ovr", 16'(kp_if.overrun), 16'h0);
        chk("co_code", 16'(kp_if.key_code), 16'h0009);
        pressed[10] = 1'b0;
        tick_windows(DB + 1);

        // Asynchronous reset in the middle of debouncing.
        wait_idle_row(1);
        pressed[4] = 1'b1;
        tick_windows(1);
        chk("deb_model", 16'(m_lock >= 0 && !m_held), 16'h1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_deb");
        pressed[4] = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset while a key is held, then scan restarts at row 0.
        press_key(0, 0, 4);
        wait_idle_row(2);
        pressed[11] = 1'b1;
        tick_windows(5);
        chk("prs_model", 16'(m_held), 16'h1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_prs");
        pressed[11] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("restart_row0", 16'(row_out), 16'h000E);
        @(negedge clk);
        chk("restart_row1", 16'(row_out), 16'h000D);

        // Random presses, ghosts and acks.
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            kp_if.key_ack = ($urandom_range(0, 7) == 0);
            if (hold == 0) begin
                k = $urandom_range(0, 9);
                pat = 16'h0;
                if (k >= 4) pat[$urandom_range(0, 15)] = 1'b1;
                if (k >= 8) pat[$urandom_range(0, 15)] = 1'b1;
                pressed = pat;
                hold = $urandom_range(1, 60);
            end else begin
                hold--;
            end
        end
        kp_if.key_ack = 1'b0;
        pressed = 16'h0;
        r0 = row_out;
        tick_windows(2 * DB + 4);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (chk_en && reset) compare_all();
                end
            end
            run_stimulus();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
